// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle micro-op datapath (register file, ALU, memory and I/O
// handshakes). Optional build macro DATAPATH_SEQ_R0_ZERO_EN hard-wires register 0 to zero.
module datapath_seq #(
    parameter int DATA_W = 32,
    parameter int NREG = 16,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              uop_valid,
    output logic              uop_ready,
    input  logic [2:0]        uop_op,
    input  logic [2:0]        uop_alu,
    input  logic [IDX_W-1:0]  uop_rd,
    input  logic [IDX_W-1:0]  uop_ra,
    input  logic [IDX_W-1:0]  uop_rb,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              illegal
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [2:0] OP_NOP = 3'd0, OP_MOV = 3'd1, OP_ALU = 3'd2, OP_LD = 3'd3;
    localparam logic [2:0] OP_ST = 3'd4, OP_IN = 3'd5, OP_OUT = 3'd6, OP_ILL = 3'd7;
`ifdef DATAPATH_SEQ_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, T1, T2, T3, MEM} state_t;

    state_t             state, state_nx;
    logic [2:0]         op, alu;
    logic [IDX_W-1:0]   rd, ra, rb;
    logic [DATA_W-1:0]  regs [NREG];
    logic [DATA_W-1:0]  y, z, mar, mdr, in_reg;
    logic [DATA_W-1:0]  a_val, b_val, wd;
    logic               accept, we;

    function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] f,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return ~b;
        endcase
    endfunction

    assign uop_ready = (state == IDLE) && clr;
    assign accept    = uop_valid && uop_ready;
    assign busy      = (state != IDLE);
    assign mem_req   = (state == MEM);
    assign mem_we    = mem_req && (op == OP_ST);
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign a_val     = (R0Z && ra == '0) ? '0 : regs[ra];
    assign b_val     = (R0Z && rb == '0) ? '0 : regs[rb];
    assign dbg_data  = (R0Z && dbg_sel == '0) ? '0 : regs[dbg_sel];

    // state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // next state and register-file write selection
    always_comb begin
        state_nx = state;
        we = 1'b0;
        wd = (state == T3) ? ((op == OP_ALU) ? z : mdr) : ((op == OP_MOV) ? a_val : in_reg);
        case (state)
            IDLE: if (accept && uop_op != OP_NOP && uop_op != OP_ILL) state_nx = T1;
            T1: begin
                state_nx = (op == OP_ALU || op == OP_ST) ? T2 : (op == OP_LD) ? MEM : IDLE;
                we = (op == OP_MOV || op == OP_IN);
            end
            T2: state_nx = (op == OP_ALU) ? T3 : MEM;
            T3: begin
                state_nx = IDLE;
                we = 1'b1;
            end
            MEM: if (mem_ack) state_nx = (op == OP_LD) ? T3 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // register file: single write port, register 0 optionally read-only zero
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && !(R0Z && rd == '0)) begin
            regs[rd] <= wd;
        end
    end

    // micro-op latch, internal datapath registers and I/O
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            {op, alu, rd, ra, rb} <= '0;
            {y, z, mar, mdr, in_reg, out_port} <= '0;
            illegal <= 1'b0;
        end else begin
            in_reg  <= in_port;
            illegal <= accept && (uop_op == OP_ILL);
            if (accept) {op, alu, rd, ra, rb} <= {uop_op, uop_alu, uop_rd, uop_ra, uop_rb};
            if (state == T1 && op == OP_ALU) y <= a_val;
            if (state == T1 && (op == OP_LD || op == OP_ST)) mar <= a_val;
            if (state == T1 && op == OP_OUT) out_port <= a_val;
            if (state == T2 && op == OP_ALU) z <= alu_f(alu, y, b_val);
            if (state == T2 && op == OP_ST) mdr <= b_val;
            if (state == MEM && mem_ack && op == OP_LD) mdr <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed micro-op sequences with a time-stamped scoreboard checked by a monitor
module tb_datapath_seq;
    localparam int K_REG = 0, K_OUT = 1, K_ILL = 2, K_REQ = 3, K_ADDR = 4;
    localparam int K_WDATA = 5, K_WE = 6, K_RDY = 7, K_BUSY = 8;
`ifdef DATAPATH_SEQ_R0_ZERO_EN
    localparam logic [31:0] R0_EXP = 32'h0;
`else
    localparam logic [31:0] R0_EXP = 32'h5;
`endif

    typedef struct {int at; int kind; int sel; logic [31:0] exp;} ent_t;
    typedef struct {logic [2:0] alu; int rd; int ra; int rb; logic [31:0] exp;} alu_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        uop_valid = 1'b0;
    logic        uop_ready;
    logic [2:0]  uop_op = '0, uop_alu = '0;
    logic [3:0]  uop_rd = '0, uop_ra = '0, uop_rb = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        mem_ack = 1'b0;
    logic [31:0] in_port = '0;
    logic [31:0] out_port;
    logic [3:0]  dbg_sel = '0;
    logic [31:0] dbg_data;
    logic        busy, illegal;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mdelay = 0;
    int   mcnt = 0;
    ent_t sb[$];
    ent_t e;
    logic [31:0] act;
    string names [9] = '{"reg", "out_port", "illegal", "mem_req", "mem_addr",
                         "mem_wdata", "mem_we", "uop_ready", "busy"};

    datapath_seq dut (
        .clk(clk), .clr(clr), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_op(uop_op), .uop_alu(uop_alu), .uop_rd(uop_rd), .uop_ra(uop_ra), .uop_rb(uop_rb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .in_port(in_port), .out_port(out_port),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: acks after mdelay wait cycles of a request
    always @(negedge clk) begin
        mcnt = mem_req ? mcnt + 1 : 0;
        mem_ack = mem_req && (mcnt > mdelay);
    end

    task automatic exp_at(input int at, input int kind, input int sel, input logic [31:0] v);
        sb.push_back('{at, kind, sel, v});
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_OUT:   return out_port;
            K_ILL:   return 32'(illegal);
            K_REQ:   return 32'(mem_req);
            K_ADDR:  return mem_addr;
            K_WDATA: return mem_wdata;
            K_WE:    return 32'(mem_we);
            K_RDY:   return 32'(uop_ready);
            K_BUSY:  return 32'(busy);
            default: return dbg_data;
        endcase
    endfunction

    // monitor: each cycle, pop and compare every entry due now
    initial forever begin
        @(negedge clk);
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                e = sb[i];
                sb.delete(i);
                if (e.kind == K_REG) begin
                    dbg_sel = 4'(e.sel);
                    #1;
                end
                act = observe(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s[%0d] cycle %0d: got %h expected %h", names[e.kind], e.sel, cyc, act, e.exp);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] alu, input int rd,
                         input int ra, input int rb, output int acc);
        uop_op = op;
        uop_alu = alu;
        uop_rd = 4'(rd);
        uop_ra = 4'(ra);
        uop_rb = 4'(rb);
        uop_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        uop_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && !uop_ready; i++) @(negedge clk);
        if (!uop_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: uop_ready still %b after 50 cycles, expected 1", uop_ready);
        end
    endtask

    alu_t tbl [11] = '{
        '{3'd1, 4, 2, 3, 32'h4},         '{3'd5, 5, 2, 3, 32'h38},
        '{3'd0, 7, 2, 3, 32'hA},         '{3'd2, 8, 2, 3, 32'h3},
        '{3'd3, 9, 2, 3, 32'h7},         '{3'd4, 10, 2, 3, 32'h4},
        '{3'd6, 11, 5, 3, 32'h7},        '{3'd7, 12, 2, 3, 32'hFFFF_FFFC},
        '{3'd1, 13, 3, 2, 32'hFFFF_FFFC}, '{3'd1, 13, 13, 2, 32'hFFFF_FFF5},
        '{3'd5, 14, 3, 5, 32'h0300_0000}
    };

    initial begin
        int acc;
        #1 clr = 1'b0;
        @(negedge clk);
        exp_at(cyc + 1, K_RDY, 0, 0);
        exp_at(cyc + 1, K_BUSY, 0, 0);
        exp_at(cyc + 1, K_REQ, 0, 0);
        exp_at(cyc + 1, K_WE, 0, 0);
        exp_at(cyc + 1, K_OUT, 0, 0);
        exp_at(cyc + 1, K_REG, 1, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        exp_at(cyc, K_RDY, 0, 1);
        in_port = 32'h5;
        issue(3'd5, 3'd0, 0, 0, 0, acc);
        exp_at(acc + 1, K_REG, 0, R0_EXP);
        wait_idle();
        issue(3'd1, 3'd0, 1, 0, 0, acc);
        exp_at(acc + 1, K_REG, 1, R0_EXP);
        wait_idle();
        in_port = 32'h7;
        issue(3'd5, 3'd0, 2, 0, 0, acc);
        exp_at(acc + 1, K_REG, 2, 32'h7);
        wait_idle();
        in_port = 32'h3;
        issue(3'd5, 3'd0, 3, 0, 0, acc);
        exp_at(acc + 1, K_REG, 3, 32'h3);
        wait_idle();
        foreach (tbl[i]) begin
            issue(3'd2, tbl[i].alu, tbl[i].rd, tbl[i].ra, tbl[i].rb, acc);
            if (i == 0) begin
                exp_at(acc + 2, K_REG, tbl[i].rd, 0);
                exp_at(acc + 2, K_BUSY, 0, 1);
                exp_at(acc + 3, K_RDY, 0, 1);
            end
            exp_at(acc + 3, K_REG, tbl[i].rd, tbl[i].exp);
            wait_idle();
        end
        issue(3'd6, 3'd0, 0, 4, 0, acc);
        exp_at(acc, K_OUT, 0, 0);
        exp_at(acc + 1, K_OUT, 0, 32'h4);
        wait_idle();
        mdelay = 4;
        issue(3'd4, 3'd0, 0, 2, 3, acc);
        exp_at(acc + 1, K_REQ, 0, 0);
        for (int k = 2; k <= 6; k++) begin
            exp_at(acc + k, K_REQ, 0, 1);
            exp_at(acc + k, K_ADDR, 0, 32'h7);
            exp_at(acc + k, K_WDATA, 0, 32'h3);
            exp_at(acc + k, K_WE, 0, 1);
            exp_at(acc + k, K_RDY, 0, 0);
        end
        exp_at(acc + 7, K_REQ, 0, 0);
        exp_at(acc + 7, K_WE, 0, 0);
        exp_at(acc + 7, K_RDY, 0, 1);
        wait_idle();
        mdelay = 0;
        issue(3'd3, 3'd0, 6, 2, 0, acc);
        exp_at(acc + 1, K_REQ, 0, 1);
        exp_at(acc + 1, K_WE, 0, 0);
        exp_at(acc + 1, K_ADDR, 0, 32'h7);
        exp_at(acc + 2, K_REG, 6, 0);
        exp_at(acc + 3, K_REG, 6, 32'hDEAD_BEEF);
        exp_at(acc + 3, K_RDY, 0, 1);
        wait_idle();
        issue(3'd7, 3'd0, 4, 2, 3, acc);
        exp_at(acc, K_ILL, 0, 1);
        exp_at(acc, K_RDY, 0, 1);
        exp_at(acc, K_BUSY, 0, 0);
        exp_at(acc + 1, K_ILL, 0, 0);
        exp_at(acc + 1, K_REG, 4, 32'h4);
        exp_at(acc + 1, K_OUT, 0, 32'h4);
        wait_idle();
        issue(3'd0, 3'd0, 4, 2, 3, acc);
        exp_at(acc, K_RDY, 0, 1);
        exp_at(acc, K_ILL, 0, 0);
        exp_at(acc, K_BUSY, 0, 0);
        wait_idle();
        @(negedge clk);
        mdelay = 20;
        issue(3'd3, 3'd0, 6, 3, 0, acc);
        exp_at(acc + 1, K_REQ, 0, 1);
        @(negedge clk);
        @(posedge clk);
        #2 clr = 1'b0;
        exp_at(cyc, K_REQ, 0, 0);
        exp_at(cyc, K_BUSY, 0, 0);
        exp_at(cyc, K_RDY, 0, 0);
        exp_at(cyc, K_OUT, 0, 0);
        exp_at(cyc, K_REG, 6, 0);
        exp_at(cyc, K_REG, 4, 0);
        exp_at(cyc, K_REG, 2, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        in_port = 32'h55;
        issue(3'd5, 3'd0, 7, 0, 0, acc);
        exp_at(acc + 1, K_REG, 7, 32'h55);
        wait_idle();
        repeat (3) @(negedge clk);
        #4;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: never checked (due cycle %0d, expected %h)", names[sb[i].kind], sb[i].sel, sb[i].at, sb[i].exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have parameter DATA_W, 32, bus/register/memory data width (>=8).
REQ-002 SHALL have parameter NREG, 16, general registers (power of 2, >=4); IDX_W = clog2(NREG).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port clr  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports uop_valid in 1 / uop_ready out 1; micro-op handshake.
REQ-006 SHALL have ports uop_op in 3, uop_alu in 3, uop_rd/uop_ra/uop_rb in IDX_W; micro-op fields.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out DATA_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ack in 1; memory handshake.
REQ-008 SHALL have ports in_port in DATA_W, out_port out DATA_W; I/O ports.
REQ-009 SHALL have ports dbg_sel in IDX_W, dbg_data out DATA_W (combinational register read), busy out 1, illegal out 1.

Function
REQ-010 SHALL accept a micro-op on the rising edge where uop_valid&&uop_ready, latching all fields; uop_ready = 1 only in IDLE and clr high.
REQ-011 SHALL implement states IDLE, T1, T2, T3, MEM; busy = (state!=IDLE).
REQ-012 SHALL decode uop_op: 000 NOP, 001 MOV, 010 ALU, 011 LD, 100 ST, 101 IN, 110 OUT, 111 illegal.
REQ-013 NOP: stays IDLE; uop_ready remains 1.
REQ-014 MOV: T1 reg[rd]<=reg[ra]; then IDLE (rd updated 1 cycle after accept).
REQ-015 ALU: T1 Y<=reg[ra]; T2 Z<=f(Y,reg[rb]); T3 reg[rd]<=Z; then IDLE (3-cycle latency).
REQ-016 ALU f by uop_alu: 000 ADD, 001 SUB (Y-B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR logical, 111 NOT B; shift amount = B mod DATA_W (low clog2(DATA_W) bits); results truncated to DATA_W, carries discarded.
REQ-017 LD: T1 MAR<=reg[ra]; MEM assert mem_req=1, mem_we=0, mem_addr=MAR until edge with mem_ack=1, then MDR<=mem_rdata; T3 reg[rd]<=MDR; then IDLE.
REQ-018 ST: T1 MAR<=reg[ra]; T2 MDR<=reg[rb]; MEM assert mem_req=1, mem_we=1, mem_addr=MAR, mem_wdata=MDR until edge with mem_ack=1; then IDLE.
REQ-019 mem_req SHALL be driven from registered state only; mem_ack already high on first MEM cycle completes in that cycle (min one MEM cycle); mem_ack outside MEM ignored; no timeout.
REQ-020 mem_addr/mem_wdata SHALL stay stable while mem_req=1; mem_we=0 whenever mem_req=0.
REQ-021 IN: in_port sampled into an internal register every cycle; T1 reg[rd]<=that register (one-cycle-old value).
REQ-022 OUT: T1 out_port<=reg[ra]; out_port holds otherwise.
REQ-023 illegal op: pulses illegal=1 for exactly the cycle after accept, no state change, stays IDLE.
REQ-024 Register reads during an op SHALL see values written by earlier ops; rd==ra or rd==rb permitted with operands read before write.
REQ-025 At most one register write per cycle; dbg_data = reg[dbg_sel] combinational, reflecting writes after the edge.

Reset
REQ-026 clr low SHALL asynchronously set all registers, Y, Z, MAR, MDR, in-port register, out_port to 0, state IDLE, mem_req=0, mem_we=0, illegal=0, busy=0, uop_ready=0.
REQ-027 clr low mid-operation (including MEM with mem_req high) SHALL abort the op with no further register or memory effect; first accept possible on first rising edge with clr high.

Configuration
REQ-028 Macro DATAPATH_SEQ_R0_ZERO_EN defined: register 0 reads as 0 on all paths (incl. dbg_data) and writes to it are discarded; undefined: register 0 is an ordinary register.

Verification
REQ-029 Reset then MOV r1<-r0 with DATAPATH_SEQ_R0_ZERO_EN, prior IN r0 while in_port=32'h5 -> dbg r1=0; without macro -> r1=32'h5.
REQ-030 IN r2 (in_port=32'h0000_0007), IN r3 (32'h0000_0003), ALU SUB r4<-r2,r3 -> r4=32'h4 exactly 3 cycles after accept; SHL r5<-r2,r3 -> 32'h38.
REQ-031 ST mem[r2]<-r3 with mem_ack delayed 4 cycles -> mem_req high 4+1 cycles, mem_addr=7, mem_wdata=3, mem_we=1 stable throughout, uop_ready low until done.
REQ-032 LD r6<-mem[r2] with mem_ack high on first MEM cycle, mem_rdata=32'hDEAD_BEEF -> r6=32'hDEAD_BEEF, total 3 cycles after accept.
REQ-033 uop_op=3'b111 -> illegal one-cycle pulse, no register change; clr low during LD MEM phase -> mem_req drops immediately, r6 and all registers 0.
REQ-034 OUT r4 -> out_port=32'h4 one cycle after accept, held through following ops until next OUT.
